rom_dl_sched: RTL

// - Sequences the HPS ROM download (ioctl stream, index 0) into the MCR3 ROM stores:
//   CPU BRAM, SDRAM port1 (sound), SDRAM port2 (sprites) and the background dl_* bus.
// - Holds ioctl_wait until each SDRAM write is acknowledged, so the download paces itself.
// - Owns rom_loaded and the core reset, including the post-load second reset pulse.
// - Sits between hps_io and the sdram / cpu_rom / mcr3 instances in emu.

---
 rtl/mcr3_dl_pkg.sv | 17 +
 rtl/rom_dl_decode.sv | 33 +++
 rtl/rom_dl_sched.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mcr3_dl_pkg.sv
// Shared types and default ROM region bounds for the MCR3 ROM download scheduler.
package mcr3_dl_pkg;

   typedef enum logic [2:0] {RG_MAIN, RG_SND, RG_SP, RG_BG, RG_NONE} region_t;
   typedef enum logic [1:0] {SYNC, IDLE, ISSUE, WAIT_ACK} state_t;

   localparam logic [24:0] DEF_MAIN_END = 25'h0E000;
   localparam logic [24:0] DEF_SND_END  = 25'h12000;
   localparam logic [24:0] DEF_SP_END   = 25'h32000;
   localparam logic [24:0] DEF_BG_END   = 25'h3A000;
   localparam int          DEF_RST_W    = 16;

   function automatic logic is_sdram(input region_t rg);
      return (rg == RG_SND) || (rg == RG_SP);
   endfunction

endpackage

// File: rtl/rom_dl_decode.sv
// Maps a download byte address to its ROM region and the offset inside that region.
module rom_dl_decode
   import mcr3_dl_pkg::*;
#(
   parameter logic [24:0] MAIN_END = DEF_MAIN_END,
   parameter logic [24:0] SND_END  = DEF_SND_END,
   parameter logic [24:0] SP_END   = DEF_SP_END,
   parameter logic [24:0] BG_END   = DEF_BG_END
) (
   input  logic [24:0] addr,
   output region_t     region,
   output logic [24:0] offset
);

   always_comb begin
      region = RG_NONE;
      offset = '0;
      if (addr < MAIN_END) begin
         region = RG_MAIN;
         offset = addr;
      end else if (addr < SND_END) begin
         region = RG_SND;
         offset = addr - MAIN_END;
      end else if (addr < SP_END) begin
         region = RG_SP;
         offset = addr - SND_END;
      end else if (addr < BG_END) begin
         region = RG_BG;
         offset = addr - SP_END;
      end
   end

endmodule

// File: rtl/rom_dl_sched.sv
// Sequences the index-0 HPS ROM download into BRAM, SDRAM port1/port2 and the BG dl_* bus.
// Optional feature: define ROM_CKSUM_EN to add the cksum output (sum of accepted bytes).
module rom_dl_sched
   import mcr3_dl_pkg::*;
#(
   parameter logic [24:0] MAIN_END = DEF_MAIN_END,
   parameter logic [24:0] SND_END  = DEF_SND_END,
   parameter logic [24:0] SP_END   = DEF_SP_END,
   parameter logic [24:0] BG_END   = DEF_BG_END,
   parameter int          RST_W    = DEF_RST_W
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic        cpu_we,
   output logic [15:0] cpu_addr,
   output logic [7:0]  cpu_d,
   output logic        port1_req,
   input  logic        port1_ack,
   output logic        port2_req,
   input  logic        port2_ack,
   output logic [24:0] sd_addr,
   output logic [7:0]  sd_d,
   output logic        dl_wr,
   output logic [24:0] dl_addr,
   output logic [7:0]  dl_data,
   output logic        rom_loaded,
   output logic        core_reset,
   output logic        ovf_err
`ifdef ROM_CKSUM_EN
   ,
   output logic [15:0] cksum
`endif
);

   state_t           state, state_n;
   region_t          in_rg, pd_rg, cur_rg, lat_rg;
   logic [24:0]      in_off, pd_off, cur_off, lat_off, pend_addr;
   logic [7:0]       cur_d, lat_d, pend_d;
   logic             pend_vld, act_p2, dl_q, done_pend;
   logic [RST_W-1:0] cnt;
   logic             dl_act, wr_qual, ack_ok, take_in, take_pend;
   logic             pend_load, pend_ovf, dl_track, dl_rise, dl_fall, drained;

   assign dl_act  = ioctl_download & (ioctl_index == 8'd0);
   assign wr_qual = ioctl_wr & dl_act;

   rom_dl_decode #(.MAIN_END(MAIN_END), .SND_END(SND_END), .SP_END(SP_END), .BG_END(BG_END))
      u_dec_in (.addr(ioctl_addr), .region(in_rg), .offset(in_off));

   rom_dl_decode #(.MAIN_END(MAIN_END), .SND_END(SND_END), .SP_END(SP_END), .BG_END(BG_END))
      u_dec_pend (.addr(pend_addr), .region(pd_rg), .offset(pd_off));

   assign ack_ok = act_p2 ? (port2_ack == port2_req) : (port1_ack == port1_req);

   always_comb begin
      state_n   = state;
      take_in   = 1'b0;
      take_pend = 1'b0;
      case (state)
         SYNC:     state_n = IDLE;
         IDLE: begin
            if (pend_vld) begin
               take_pend = 1'b1;
               state_n   = ISSUE;
            end else if (wr_qual) begin
               take_in = 1'b1;
               state_n = ISSUE;
            end
         end
         ISSUE:    state_n = is_sdram(cur_rg) ? WAIT_ACK : IDLE;
         WAIT_ACK: if (ack_ok) state_n = IDLE;
         default:  state_n = SYNC;
      endcase
   end

   // A pending slot freed by promotion this cycle can take the incoming write at once.
   assign pend_load = wr_qual & ~take_in & (~pend_vld | take_pend);
   assign pend_ovf  = wr_qual & ~take_in & pend_vld & ~take_pend;
   assign lat_rg    = take_pend ? pd_rg  : in_rg;
   assign lat_off   = take_pend ? pd_off : in_off;
   assign lat_d     = take_pend ? pend_d : ioctl_dout;

   // Download-edge tracking is frozen while an SDRAM ack is outstanding.
   assign dl_track = (state != WAIT_ACK);
   assign dl_rise  = dl_track & dl_act & ~dl_q;
   assign dl_fall  = dl_track & ~dl_act & dl_q;
   assign drained  = (state == IDLE) & ~pend_vld;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) state <= SYNC;
      else       state <= state_n;
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         cur_rg     <= RG_NONE;
         pend_vld   <= 1'b0;
         act_p2     <= 1'b0;
         port1_req  <= 1'b0;
         port2_req  <= 1'b0;
         ioctl_wait <= 1'b0;
         cpu_we     <= 1'b0;
         cpu_addr   <= '0;
         cpu_d      <= '0;
         sd_addr    <= '0;
         sd_d       <= '0;
         dl_wr      <= 1'b0;
         dl_addr    <= '0;
         dl_data    <= '0;
         rom_loaded <= 1'b0;
         done_pend  <= 1'b0;
         dl_q       <= 1'b0;
         ovf_err    <= 1'b0;
         cnt        <= '1;
      end else begin
         cpu_we <= 1'b0;
         dl_wr  <= 1'b0;
         if (state == SYNC) begin
            port1_req <= port1_ack;
            port2_req <= port2_ack;
         end
         if (take_in | take_pend) begin
            cur_rg     <= lat_rg;
            act_p2     <= (lat_rg == RG_SP);
            ioctl_wait <= is_sdram(lat_rg);
         end
         if (pend_load)      pend_vld <= 1'b1;
         else if (take_pend) pend_vld <= 1'b0;
         if (pend_ovf) ovf_err <= 1'b1;
         if (state == ISSUE) begin
            case (cur_rg)
               RG_MAIN: begin
                  cpu_we   <= 1'b1;
                  cpu_addr <= cur_off[15:0];
                  cpu_d    <= cur_d;
               end
               RG_SND: begin
                  port1_req <= ~port1_req;
                  sd_addr   <= cur_off;
                  sd_d      <= cur_d;
               end
               RG_SP: begin
                  port2_req <= ~port2_req;
                  sd_addr   <= cur_off;
                  sd_d      <= cur_d;
               end
               RG_BG: begin
                  dl_wr   <= 1'b1;
                  dl_addr <= cur_off;
                  dl_data <= cur_d;
               end
               default: ;
            endcase
         end
         if ((state == WAIT_ACK) && ack_ok) ioctl_wait <= 1'b0;
         if (dl_track) dl_q <= dl_act;
         if (dl_rise) begin
            rom_loaded <= 1'b0;
            done_pend  <= 1'b0;
         end else if (dl_fall | done_pend) begin
            rom_loaded <= rom_loaded | drained;
            done_pend  <= ~drained;
         end
         // Counter reaching 1 produces the single post-load reset pulse.
         if (!rom_loaded)    cnt <= '1;
         else if (cnt != '0) cnt <= cnt - {{(RST_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk_sys) begin
      if (take_in | take_pend) begin
         cur_off <= lat_off;
         cur_d   <= lat_d;
      end
      if (pend_load) begin
         pend_addr <= ioctl_addr;
         pend_d    <= ioctl_dout;
      end
   end

`ifdef ROM_CKSUM_EN
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)                                 cksum <= '0;
      else if (dl_rise)                          cksum <= '0;
      else if ((state == ISSUE) && (cur_rg != RG_NONE)) cksum <= cksum + {8'd0, cur_d};
   end
`endif

   assign core_reset = reset | dl_act | ~rom_loaded | (cnt == {{(RST_W-1){1'b0}}, 1'b1});

endmodule
